// File: rtl/inv_substitution_layer_seq_pkg.sv
// Shared ASCON definitions for the sequential inverse substitution layer:
// the state word width, the controller state encoding and the inverse S-box.
package inv_substitution_layer_seq_pkg;

  localparam int WORD_W    = 64;
  localparam int NUM_WORDS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Inverse of the ASCON 5-bit S-box, entry 0 first.
  // Index bit 4 is x0, bit 0 is x4; the result uses the same ordering.
  localparam logic [0:31][4:0] INV_SBOX = {
    5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
    5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
    5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
    5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
  };

  // Table lookup shared by every S-box instance.
  function automatic logic [4:0] inv_sbox_lookup(input logic [4:0] idx);
    return INV_SBOX[idx];
  endfunction

endpackage

// File: rtl/inv_substitution_layer_seq_inv_sbox.sv
// Single bit-slice inverse ASCON S-box, purely combinational.
module ascon_inv_sbox
  import inv_substitution_layer_seq_pkg::*;
(
  input  logic [4:0] idx_i,
  output logic [4:0] sub_o
);

  assign sub_o = inv_sbox_lookup(idx_i);

endmodule

// File: rtl/inv_substitution_layer_seq.sv
// Sequential ASCON inverse substitution layer. A captured 5x64-bit state is
// inverse-substituted SLICES_PER_CYCLE bit positions per cycle, in place, and
// the same register is then presented as the result.
module inv_substitution_layer_seq
  import inv_substitution_layer_seq_pkg::*;
#(
  parameter int SLICES_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] x0_in,
  input  logic [63:0] x1_in,
  input  logic [63:0] x2_in,
  input  logic [63:0] x3_in,
  input  logic [63:0] x4_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] x0_out,
  output logic [63:0] x1_out,
  output logic [63:0] x2_out,
  output logic [63:0] x3_out,
  output logic [63:0] x4_out
);

  localparam int P      = SLICES_PER_CYCLE;
  localparam int GROUPS = WORD_W / P;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

  state_e                               state_q;
  logic [CNT_W-1:0]                     cnt_q;
  // Index 0 holds x0; this register is both working state and output.
  logic [NUM_WORDS-1:0][WORD_W-1:0]     x_q;
  logic [NUM_WORDS-1:0][WORD_W-1:0]     x_run_d;

  logic [5:0]                           base;
  logic [P-1:0][4:0]                    sb_in;
  logic [P-1:0][4:0]                    sb_out;

  // First bit position of the group handled this cycle.
  assign base = 6'(int'(cnt_q) * P);

  for (genvar j = 0; j < P; j++) begin : g_sbox
    logic [5:0] pos;
    assign pos      = base + 6'(j);
    assign sb_in[j] = {x_q[0][pos], x_q[1][pos], x_q[2][pos], x_q[3][pos], x_q[4][pos]};
    ascon_inv_sbox u_sbox (
      .idx_i (sb_in[j]),
      .sub_o (sb_out[j])
    );
  end

  // Merge the substituted group back into the otherwise unchanged state.
  always_comb begin
    x_run_d = x_q;
    for (int j = 0; j < P; j++) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        x_run_d[w][base + 6'(j)] = sb_out[j][4 - w];
      end
    end
  end

  // Controller and state register; reset wins over every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q     <= {x4_in, x3_in, x2_in, x1_in, x0_in};
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q <= x_run_d;
          // Counter parks on the last group so it never wraps mid-operation.
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags depend on the state register alone.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  assign x0_out = x_q[0];
  assign x1_out = x_q[1];
  assign x2_out = x_q[2];
  assign x3_out = x_q[3];
  assign x4_out = x_q[4];

endmodule
